// File: rtl/tsc_dump_rx_if.sv
// Signal bundle between the host readout logic (master) and the dump receiver (slave).
// Carries the capture-unit pins (sbf/sd/cd/trd) together with the host command/status/readback signals.
interface tsc_dump_rx_if #(parameter int AW = 5);
  logic          fetch;
  logic          trd;
  logic          sd;
  logic          cd;
  logic          sbf;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [AW:0]   byte_cnt;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  modport master (
    output fetch, trd, sd, cd, rd_addr,
    input  sbf, busy, done, err, err_code, byte_cnt, rd_data
  );

  modport slave (
    input  fetch, trd, sd, cd, rd_addr,
    output sbf, busy, done, err, err_code, byte_cnt, rd_data
  );
endinterface

// File: rtl/tsc_dump_rx.sv
// Transient-capture dump receiver: requests a buffer dump, deserialises SD into a byte RAM, ends on CD.
// Optional start-bit watchdog enabled by defining TSC_RX_TIMEOUT_EN.
module tsc_dump_rx #(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  tsc_dump_rx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_t      state_r;
  logic [2:0]  bit_cnt_r;
  logic [6:0]  shift_r;
  logic [AW:0] byte_cnt_r;
  logic        sbf_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic [1:0]  err_code_r;
  logic [7:0]  rd_data_r;
  logic [7:0]  mem_r [DEPTH];
  logic        wr_en_s;
  logic [7:0]  wr_byte_s;

`ifdef TSC_RX_TIMEOUT_EN
  localparam int            WDW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT - 1);
  logic [WDW-1:0] wd_r;
`endif

  // Write strobe: eighth data bit arriving with room left and no abort
  always_comb begin
    wr_en_s   = 1'b0;
    wr_byte_s = {shift_r, bus.sd};
    if ((state_r == S_SHIFT) && !bus.cd && (bit_cnt_r == 3'd7) && (byte_cnt_r != FULL)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Control FSM with registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 7'd0;
      byte_cnt_r <= '0;
      sbf_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= 2'b00;
`ifdef TSC_RX_TIMEOUT_EN
      wd_r       <= '0;
`endif
    end else begin
      sbf_r <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.fetch && bus.trd) begin
            state_r    <= S_REQ;
            sbf_r      <= 1'b1;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 2'b00;
            byte_cnt_r <= '0;
          end else begin
            state_r <= state_r;
          end
        end
        S_REQ: begin
          state_r <= S_WAIT;
`ifdef TSC_RX_TIMEOUT_EN
          wd_r    <= '0;
`endif
        end
        S_WAIT: begin
          if (bus.cd) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end else if (bus.sd) begin
            state_r   <= S_SHIFT;
            bit_cnt_r <= 3'd0;
`ifdef TSC_RX_TIMEOUT_EN
          end else if (wd_r == WD_MAX) begin
            state_r    <= S_ERR;
            err_r      <= 1'b1;
            err_code_r <= 2'b11;
            busy_r     <= 1'b0;
          end else begin
            wd_r <= wd_r + WDW'(1);
          end
`else
          end else begin
            state_r <= S_WAIT;
          end
`endif
        end
        S_SHIFT: begin
          if (bus.cd) begin
            // abort mid-byte: partial byte dropped, count untouched
            state_r    <= S_ERR;
            err_r      <= 1'b1;
            err_code_r <= 2'b01;
            busy_r     <= 1'b0;
          end else begin
            shift_r   <= {shift_r[5:0], bus.sd};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              if (byte_cnt_r != FULL) begin
                byte_cnt_r <= byte_cnt_r + ONE;
                state_r    <= S_WAIT;
`ifdef TSC_RX_TIMEOUT_EN
                wd_r       <= '0;
`endif
              end else begin
                state_r    <= S_ERR;
                err_r      <= 1'b1;
                err_code_r <= 2'b10;
                busy_r     <= 1'b0;
              end
            end else begin
              state_r <= S_SHIFT;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Byte RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[byte_cnt_r[AW-1:0]] <= wr_byte_s;
    end
  end

  // Registered host read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_r <= 8'd0;
    end else begin
      rd_data_r <= mem_r[bus.rd_addr];
    end
  end

  assign bus.sbf      = sbf_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.err_code = err_code_r;
  assign bus.byte_cnt = byte_cnt_r;
  assign bus.rd_data  = rd_data_r;

endmodule

// File: tb/tb_tsc_dump_rx.sv
// Bench for tsc_dump_rx: transaction-level expected-status model checked every cycle, plus literal pins.
// Build with TSC_RX_TIMEOUT_EN defined to exercise the watchdog path.
module tb_tsc_dump_rx;
  localparam int DEPTH   = 32;
  localparam int AW      = 5;
  localparam int TIMEOUT = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tsc_dump_rx_if #(.AW(AW)) bus ();

  tsc_dump_rx #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // expected status, updated by the stimulus tasks right after the edge that changes it
  logic       exp_sbf  = 1'b0;
  logic       exp_busy = 1'b0;
  logic       exp_done = 1'b0;
  logic       exp_err  = 1'b0;
  logic [1:0] exp_code = 2'b00;
  int         exp_cnt  = 0;
  logic [7:0] exp_mem [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("sbf",      {31'd0, bus.sbf},  {31'd0, exp_sbf});
    chk("busy",     {31'd0, bus.busy}, {31'd0, exp_busy});
    chk("done",     {31'd0, bus.done}, {31'd0, exp_done});
    chk("err",      {31'd0, bus.err},  {31'd0, exp_err});
    chk("err_code", {30'd0, bus.err_code}, {30'd0, exp_code});
    chk("byte_cnt", {26'd0, bus.byte_cnt}, exp_cnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_sbf = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    exp_code = 2'b00; exp_cnt = 0;
  endtask

  task automatic fetch_go();
    bus.fetch = 1'b1; bus.trd = 1'b1;
    step();
    exp_sbf = 1'b1; exp_busy = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    exp_code = 2'b00; exp_cnt = 0;
    bus.fetch = 1'b0; bus.trd = 1'b0;
    step();
    exp_sbf = 1'b0;
  endtask

  // start bit then the first n data bits, MSB first
  task automatic send_bits(input logic [7:0] b, input int n);
    logic [7:0] v;
    v = b;
    bus.sd = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      bus.sd = v[7-i];
      step();
    end
    bus.sd = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    send_bits(b, 8);
    if (exp_cnt < DEPTH) begin
      exp_mem[exp_cnt] = b;
      exp_cnt++;
    end else begin
      exp_err = 1'b1; exp_code = 2'b10; exp_busy = 1'b0;
    end
    repeat (gap) step();
  endtask

  task automatic finish_dump();
    bus.cd = 1'b1; bus.sd = 1'b1;
    step();
    exp_done = 1'b1; exp_busy = 1'b0;
    bus.cd = 1'b0; bus.sd = 1'b0;
  endtask

  task automatic rd(input int addr, input logic [7:0] expv, input string nm);
    bus.rd_addr = AW'(addr);
    step();
    chk(nm, {24'd0, bus.rd_data}, {24'd0, expv});
  endtask

  initial begin
    bus.fetch = 1'b0; bus.trd = 1'b0; bus.sd = 1'b0; bus.cd = 1'b0; bus.rd_addr = '0;
    repeat (2) step();
    chk("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    reset = 1'b0;
    step();

    // reset in the middle of a byte
    fetch_go();
    send_byte(8'hA7, 0);
    send_bits(8'h6B, 3);
    reset = 1'b1;
    model_reset();
    #2;
    chk("t1_busy", {31'd0, bus.busy}, 32'd0);
    chk("t1_sbf",  {31'd0, bus.sbf},  32'd0);
    chk("t1_cnt",  {26'd0, bus.byte_cnt}, 32'd0);
    step();
    bus.sd = 1'b0;
    reset = 1'b0;
    repeat (2) step();

    // three back-to-back bytes, cd together with sd at the end
    fetch_go();
    send_byte(8'hD5, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h01, 0);
    finish_dump();
    chk("t2_done", {31'd0, bus.done}, 32'd1);
    chk("t2_cnt",  {26'd0, bus.byte_cnt}, 32'd3);
    rd(0, 8'hD5, "t2_rd0");
    rd(1, 8'h3C, "t2_rd1");
    rd(2, 8'h01, "t2_rd2");

    // fetch without trd is ignored
    bus.fetch = 1'b1; bus.trd = 1'b0;
    repeat (20) step();
    bus.fetch = 1'b0;
    chk("t3_busy", {31'd0, bus.busy}, 32'd0);

    // overflow on the 33rd byte
    fetch_go();
    for (int i = 0; i < DEPTH + 1; i++) begin
      send_byte(8'((i * 7 + 3) & 255), (i % 4 == 0) ? 2 : 0);
    end
    chk("t4_err",  {31'd0, bus.err}, 32'd1);
    chk("t4_code", {30'd0, bus.err_code}, 32'd2);
    chk("t4_cnt",  {26'd0, bus.byte_cnt}, 32'd32);
    rd(31, 8'hDC, "t4_rd31");
    rd(0, exp_mem[0], "t4_rd0");
    rd(17, exp_mem[17], "t4_rd17");

    // truncated byte
    fetch_go();
    send_byte(8'h5A, 1);
    send_bits(8'hF0, 4);
    bus.cd = 1'b1;
    step();
    exp_err = 1'b1; exp_code = 2'b01; exp_busy = 1'b0;
    bus.cd = 1'b0;
    step();
    chk("t5_code", {30'd0, bus.err_code}, 32'd1);
    chk("t5_cnt",  {26'd0, bus.byte_cnt}, 32'd1);
    rd(0, 8'h5A, "t5_rd0");

    // no start bit ever arrives
    fetch_go();
`ifdef TSC_RX_TIMEOUT_EN
    repeat (TIMEOUT - 1) step();
    chk("t6_busy_pre", {31'd0, bus.busy}, 32'd1);
    step();
    exp_err = 1'b1; exp_code = 2'b11; exp_busy = 1'b0;
    step();
    chk("t6_code", {30'd0, bus.err_code}, 32'd3);
`else
    repeat (40) step();
    chk("t6_busy", {31'd0, bus.busy}, 32'd1);
    finish_dump();
    step();
    chk("t6_done", {31'd0, bus.done}, 32'd1);
`endif

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
